// File: rtl/bru_issue_sched.sv
// In-order issue scheduler in front of the BRU.
// Dispatched branch/jump uops are held in a small circular FIFO. Each entry
// watches the PRF wakeup buses for its two source tags. Only the head entry
// may issue. A redirect from the BRU empties the whole queue.

package bru_defs_pkg;
    localparam int PHYS_W  = 6;
    localparam int ROB_W   = 5;
    localparam int EPOCH_W = 2;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prd_new;
        logic [3:0]         bundle;
    } rs_uop_t;
endpackage

module bru_issue_sched
    import bru_defs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int WK_PORTS = 3
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  rs_uop_t                      enq_uop,
    input  logic [PHYS_W-1:0]            enq_prs1,
    input  logic [PHYS_W-1:0]            enq_prs2,
    input  logic                         enq_rdy1,
    input  logic                         enq_rdy2,

    input  logic [WK_PORTS-1:0]          wk_valid,
    input  logic [WK_PORTS*PHYS_W-1:0]   wk_tag,

    output logic                         iss_valid,
    input  logic                         iss_ready,
    output rs_uop_t                      iss_uop,
    output logic [PHYS_W-1:0]            iss_prs1,
    output logic [PHYS_W-1:0]            iss_prs2,

    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage. The payload is never reset; only the ready bits and the
    // pointers/occupancy carry meaning out of reset.
    rs_uop_t            uop_q  [DEPTH];
    logic [PHYS_W-1:0]  prs1_q [DEPTH];
    logic [PHYS_W-1:0]  prs2_q [DEPTH];
    logic [DEPTH-1:0]   rdy1_q;
    logic [DEPTH-1:0]   rdy2_q;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_next;

    logic               full;
    logic               enq_fire;
    logic               iss_fire;

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   hit1;
    logic [DEPTH-1:0]   hit2;
    logic               enq_hit1;
    logic               enq_hit2;

    // True when any asserted wakeup port broadcasts the given tag.
    function automatic logic wk_hit(input logic [PHYS_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WK_PORTS; p++) begin
            if (wk_valid[p] && (wk_tag[p*PHYS_W +: PHYS_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Full and empty are told apart by the separate occupancy counter, so
    // enq_ready needs no pointer comparison and never looks ahead at issue.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign enq_ready = !full;
    assign enq_fire  = enq_valid && enq_ready && !flush;

    // Issue looks only at registered ready bits, so a wakeup or an enqueue in
    // one cycle can make the head issuable no earlier than the next.
    assign iss_valid = (count_q != '0) && rdy1_q[head] && rdy2_q[head] && !flush;
    assign iss_fire  = iss_valid && iss_ready;

    assign iss_uop   = uop_q[head];
    assign iss_prs1  = prs1_q[head];
    assign iss_prs2  = prs2_q[head];
    assign count     = count_q;

    // Mark which slots currently hold live uops: those within count of head.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs      = '0;
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - head;
            ent_valid[i] = ({1'b0, offs} < count_q);
        end
    end

    // Wakeup tag matching for every stored entry and for the uop being enqueued.
    always_comb begin
        hit1     = '0;
        hit2     = '0;
        enq_hit1 = wk_hit(enq_prs1);
        enq_hit2 = wk_hit(enq_prs2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1[i] = wk_hit(prs1_q[i]);
            hit2[i] = wk_hit(prs2_q[i]);
        end
    end

    // Occupancy update: simultaneous enqueue and issue leave it unchanged.
    always_comb begin
        count_next = count_q;
        case ({enq_fire, iss_fire})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointer and occupancy registers; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (iss_fire) begin
                head <= head + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    // Ready bits: a new entry captures dispatch readiness plus any wakeup seen
    // in the same cycle; a live entry latches wakeups until it leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy1_q <= '0;
            rdy2_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_fire && (tail == PTR_W'(i))) begin
                    rdy1_q[i] <= enq_rdy1 || enq_hit1;
                    rdy2_q[i] <= enq_rdy2 || enq_hit2;
                end else begin
                    if (ent_valid[i] && hit1[i]) begin
                        rdy1_q[i] <= 1'b1;
                    end
                    if (ent_valid[i] && hit2[i]) begin
                        rdy2_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload write at the tail slot on an accepted enqueue.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            uop_q[tail]  <= enq_uop;
            prs1_q[tail] <= enq_prs1;
            prs2_q[tail] <= enq_prs2;
        end
    end

`ifndef SYNTHESIS
    // Simulation guards on queue arithmetic.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_fire && full));
            assert (!(iss_fire && (count_q == '0)));
            assert (count_q <= CNT_W'(DEPTH));
        end
    end
`endif

endmodule
